uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: serialises one 8-bit byte per request into an asynchronous frame (start bit, 8 data bits, optional parity bit, 1 stop bit) on a single line, at a bit rate derived from the system clock. It is the transmit counterpart of the team's UART receiver, running at the same `Fclk`/`Fuart` configuration. It sits between frame-generation logic, which presents bytes with a strobe, and the board TX pin.

## Interface
- `Fclk`, 100000000 — system clock frequency, Hz
- `Fuart`, 9600 — line bit rate, bit/s
- `BIT_CYCLES`, Fclk/Fuart (integer division) — clocks per bit; 10416 at the defaults; must be ≥ 2
- `clk_Tx`  input  1  system clock; all logic is on its rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in`  input  8  byte to send; sampled only in the cycle a request is accepted
- `start`  input  1  request strobe; level-sampled each cycle
- `Tx_out`  output  1  serial line; idles high
- `busy`  output  1  high while a frame is in progress
- `done`  output  1  one-cycle pulse when the stop bit completes

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- IDLE:
  - `Tx_out`=1, `busy`=0.
  - When `start`=1, latch `data_in` into the shift register, clear the bit-cycle counter and the bit index, and go to START.
- START: `Tx_out`=0 for `BIT_CYCLES` cycles, then go to DATA.
- DATA:
  - 8 bits, MSB first: `data_in[7]` is sent first and `data_in[0]` last.
  - Each bit is held for `BIT_CYCLES` cycles.
  - The 3-bit index counts 0..7; at the end of index 7 go to PARITY if it is compiled in, otherwise to STOP.
- STOP: `Tx_out`=1 for `BIT_CYCLES` cycles, then return to IDLE and pulse `done`.
- Bit-cycle counter:
  - Width is `$clog2(BIT_CYCLES)`.
  - Counts 0..`BIT_CYCLES`-1; the terminal count advances the bit or state and wraps the counter to 0.
- Requests:
  - `start` while `busy`=1 is ignored. No queueing, no error flag.
  - The latched byte is immune to `data_in` changes after acceptance.
- `Tx_out` is driven directly from a flop (no combinational path to the pin).
- Reset values: `Tx_out`=1, `busy`=0, `done`=0, state=IDLE, counters=0, shift register=0.
- Reset asserted mid-frame: the next edge forces the line high and returns to IDLE. The truncated frame is abandoned and `done` is not pulsed.

## Timing
- Request accepted at edge N (IDLE, `start`=1):
  - `busy`=1 and `Tx_out`=0 from edge N+1.
  - Start-bit falling edge latency: exactly 1 cycle.
- Frame length, from `busy` rising to `busy` falling:
  - 10×`BIT_CYCLES` without parity.
  - 11×`BIT_CYCLES` with parity.
- `done` is high for exactly the one cycle in which the state is back in IDLE and `busy`=0.
- Back-to-back frames:
  - `start` sampled high in the `done` cycle is accepted.
  - The next start bit begins the following cycle, giving a minimum inter-frame gap of 1 clock beyond the stop bit.
- `start` held high continuously produces contiguous frames, each carrying the `data_in` value present at its own acceptance edge.

## Configuration
- `UART_TX_PARITY_EN`, defined:
  - Adds the PARITY state after DATA.
  - Sends even parity (XOR of the 8 latched bits) for `BIT_CYCLES` cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state, no parity logic, 10-bit frame.

## Structure
- Package `uart_pkg`:
  - State enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Constant `UART_DATA_BITS`=8.
  - Function computing `BIT_CYCLES` from `Fclk`/`Fuart`.
  - Shared with the receiver.
- Sub-module `uart_baud_tick`:
  - Parameterised by `BIT_CYCLES`.
  - Inputs `clk_Tx`, `reset`, `clear`.
  - Output `tick`: high in the cycle the counter reaches `BIT_CYCLES`-1, then wraps.
  - The FSM asserts `clear` on request acceptance.

## Test plan
- Sim parameters `Fclk`=1600000, `Fuart`=100000 (`BIT_CYCLES`=16), parity off. Send 0xA5 → `Tx_out` shows 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. `done` pulses at cycle 160 after acceptance.
- `start` pulsed at cycles 5 and 40 of a frame with `data_in`=0xFF → second request ignored. Line carries only the first byte. `busy` stays high for 160 cycles.
- `start` held high with `data_in`=0x00 then 0x81 at the `done` cycle → two contiguous frames, 0x00 then 0x81. Line high for exactly 16+1 cycles between them.
- `reset` asserted at cycle 70 of a frame sending 0x3C → `Tx_out`=1 and `busy`=0 the next cycle, no `done` pulse. A new 0x3C request then completes normally.
- `UART_TX_PARITY_EN` defined: send 0x07 → parity bit 1; send 0x03 → parity bit 0. Frame is 176 cycles; `done` at cycle 176.
- Default parameters: send 0x55 → each bit is exactly 10416 cycles, measured between line transitions.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM state
// encoding, data width, bit-period helper and parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  function automatic int calc_bit_cycles(input int fclk, input int fuart);
    return fclk / fuart;
  endfunction

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-request handshake and line outputs of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data_in;
  logic                      start;
  logic                      Tx_out;
  logic                      busy;
  logic                      done;

  modport master (output data_in, start, input Tx_out, busy, done);
  modport slave  (input data_in, start, output Tx_out, busy, done);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 and flags the terminal count.
module uart_baud_tick #(
  parameter int BIT_CYCLES = 16
) (
  input  logic clk_Tx,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  always_ff @(posedge clk_Tx) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits MSB first, optional even parity
// (compiled in with `define UART_TX_PARITY_EN), one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int Fclk  = 100000000,
  parameter int Fuart = 9600
) (
  input logic      clk_Tx,
  input logic      reset,
  uart_tx_if.slave bus
);

  localparam int         BIT_CYCLES = calc_bit_cycles(Fclk, Fuart);
  localparam logic [2:0] LAST_IDX   = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      baud_clear;
  logic                      baud_tick;

  uart_baud_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_baud_tick (
    .clk_Tx(clk_Tx),
    .reset (reset),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  // Every output is computed for the state being entered, so the pin sees a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    baud_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.data_in;
          idx_d      = 3'd0;
          baud_clear = 1'b1;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = START;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_d    = shift_q[UART_DATA_BITS-1];
          state_d = DATA;
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          // Rotate rather than shift so the latched byte survives for parity.
          shift_d = {shift_q[UART_DATA_BITS-2:0], shift_q[UART_DATA_BITS-1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = even_parity(shift_q);
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[UART_DATA_BITS-2];
          end
        end else begin
          tx_d = shift_q[UART_DATA_BITS-1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          tx_d = tx_q;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk_Tx) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= {UART_DATA_BITS{1'b0}};
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Tx_out = tx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at BIT_CYCLES=16; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int BC = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
  localparam int FRAME_BITS = 11;
`else
  localparam bit PAR_EN     = 1'b0;
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BC;

  logic clk = 1'b0;
  logic reset;

  uart_tx_if bus_if ();

  uart_tx #(
    .Fclk (1600000),
    .Fuart(100000)
  ) dut (
    .clk_Tx(clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         frames_checked = 0;
  int         frames_expected = 0;
  int         done_cnt = 0;
  logic       mon_abort = 1'b0;
  logic [7:0] exp_q[$];
  time        start_t[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected line level of frame bit idx: start, data MSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[8-idx];
    if (PAR_EN && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Line monitor: checks every cycle of each frame against the scoreboard head.
  initial begin : monitor
    logic       prev_tx;
    logic [7:0] exp;
    logic [7:0] rx;
    int         line_err;
    int         busy_err;
    bit         aborted;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_tx === 1'b1 && bus_if.Tx_out === 1'b0) begin
        start_t.push_back($time);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_frame", 32'd1, 32'd0);
          exp = 8'h00;
        end else begin
          exp = exp_q.pop_front();
        end
        line_err = 0;
        busy_err = 0;
        rx       = 8'h00;
        aborted  = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (mon_abort) begin
            aborted = 1'b1;
            break;
          end
          if (bus_if.Tx_out !== exp_bit(exp, k / BC)) line_err++;
          if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) busy_err++;
          if ((k % BC) == BC / 2 && (k / BC) >= 1 && (k / BC) <= 8) rx = {rx[6:0], bus_if.Tx_out};
        end
        if (!aborted) begin
          @(negedge clk);
          check_eq("done_pulse", {31'd0, bus_if.done}, 32'd1);
          check_eq("busy_fall", {31'd0, bus_if.busy}, 32'd0);
          check_eq("line_idle_after_stop", {31'd0, bus_if.Tx_out}, 32'd1);
          check_eq("line_bits", line_err, 32'd0);
          check_eq("busy_in_frame", busy_err, 32'd0);
          check_eq("rx_byte", {24'd0, rx}, {24'd0, exp});
          frames_checked++;
        end
      end
      prev_tx = bus_if.Tx_out;
    end
  end

  // Counts every done pulse seen on the bus.
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_cnt++;
  end

  task automatic send(input logic [7:0] b);
    bus_if.data_in = b;
    bus_if.start   = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    bus_if.start   = 1'b0;
    bus_if.data_in = ~b;
    check_eq("start_latency_tx", {31'd0, bus_if.Tx_out}, 32'd0);
    check_eq("start_latency_busy", {31'd0, bus_if.busy}, 32'd1);
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = 4 * FRAME_CYC;
    while (frames_checked < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_eq("frames_completed", frames_checked, target);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] pats[4];
    int         base;
    time        gap;
    pats = '{8'h07, 8'h03, 8'h80, 8'h01};
    reset          = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", {31'd0, bus_if.Tx_out}, 32'd1);
    check_eq("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus_if.done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA5);
    frames_expected++;
    wait_frames(frames_expected);

    // Requests while busy are dropped; data_in carries 0xFF meanwhile.
    send(8'h12);
    frames_expected++;
    repeat (4) @(negedge clk);
    bus_if.data_in = 8'hFF;
    bus_if.start   = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (34) @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_frames(frames_expected);
    repeat (40) @(negedge clk);
    check_eq("ignored_req_tx", {31'd0, bus_if.Tx_out}, 32'd1);
    check_eq("ignored_req_busy", {31'd0, bus_if.busy}, 32'd0);

    // start held high: the done cycle accepts the next byte.
    base           = start_t.size();
    bus_if.data_in = 8'h00;
    bus_if.start   = 1'b1;
    exp_q.push_back(8'h00);
    repeat (FRAME_CYC + 1) @(negedge clk);
    bus_if.data_in = 8'h81;
    exp_q.push_back(8'h81);
    @(negedge clk);
    bus_if.start = 1'b0;
    frames_expected += 2;
    wait_frames(frames_expected);
    gap = (start_t.size() >= base + 2) ? (start_t[base+1] - start_t[base]) / 10 : 0;
    check_eq("b2b_gap_cycles", gap[31:0], FRAME_CYC + 1);

    // Reset mid-frame abandons it without a done pulse.
    send(8'h3C);
    repeat (69) @(negedge clk);
    mon_abort = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midreset_tx", {31'd0, bus_if.Tx_out}, 32'd1);
    check_eq("midreset_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("midreset_done", {31'd0, bus_if.done}, 32'd0);
    repeat (3) @(negedge clk);
    mon_abort = 1'b0;
    send(8'h3C);
    frames_expected++;
    wait_frames(frames_expected);

    for (int i = 0; i < 4; i++) begin
      send(pats[i]);
      frames_expected++;
      wait_frames(frames_expected);
    end

    check_eq("done_count", done_cnt, frames_expected);
    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
